// File: rtl/truth_table_sequencer.sv
// Truth-table scan controller: steps every input vector through a combinational DUT,
// captures its output and scores it against a golden table. Optional macro: TT_HALT_ON_ERR_EN.
module truth_table_sequencer #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [(1<<N_IN)-1:0]  expected,
    input  logic                  f_in,
    output logic [N_IN-1:0]       x_out,
    output logic                  busy,
    output logic                  done,
    output logic [(1<<N_IN)-1:0]  table_out,
    output logic [N_IN:0]         err_count,
    output logic [N_IN-1:0]       err_idx,
    output logic                  match
);
    localparam int T = 1 << N_IN;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]      state;
    logic [3:0]      cnt;
    logic [N_IN-1:0] idx;
    logic            mism;
    logic            last;
    logic            halt;
    logic [N_IN:0]   err_next;

    always_comb begin
        mism     = (f_in != expected[idx]);
        err_next = err_count + {{N_IN{1'b0}}, mism};
        last     = (idx == N_IN'(T - 1));
`ifdef TT_HALT_ON_ERR_EN
        halt     = mism;
`else
        halt     = 1'b0;
`endif
    end

    // The vector index register drives the DUT directly, so x_out is registered.
    assign x_out = idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
            err_count <= '0;
            err_idx   <= '0;
            match     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_WAIT;
                        cnt       <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        match     <= 1'b0;
                        table_out <= '0;
                        err_count <= '0;
                        err_idx   <= '0;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'(SETTLE - 1))
                        state <= S_SAMPLE;
                    else
                        cnt <= cnt + 4'd1;
                end
                S_SAMPLE: begin
                    table_out[idx] <= f_in;
                    err_count      <= err_next;
                    if (mism && err_count == '0)
                        err_idx <= idx;
                    if (last || halt) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        match <= (err_next == '0);
                    end else begin
                        state <= S_WAIT;
                        idx   <= idx + 1'b1;
                        cnt   <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: two sequencer instances (SETTLE=1 and SETTLE=3) each driving a
// small 2-input function selected by the bench.
module tb_truth_table_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0, start3 = 1'b0;
    logic [3:0] exp1 = '0, exp3 = '0;
    logic [1:0] sel = '0;
    logic       f1, f3;
    logic [1:0] x1, x3;
    logic       busy1, done1, match1, busy3, done3, match3;
    logic [3:0] tab1, tab3;
    logic [2:0] err1, err3;
    logic [1:0] eidx1, eidx3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // x = MSB, y = LSB
    always_comb begin
        case (sel)
            2'd0:    f1 = ~(x1[1] & ~x1[0]) | (x1[1] | x1[0]);
            2'd1:    f1 = x1[1] & x1[0];
            default: f1 = x1[1] ^ x1[0];
        endcase
        f3 = x3[1] ^ x3[0];
    end

    truth_table_sequencer #(.N_IN(2), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .f_in(f1),
        .x_out(x1), .busy(busy1), .done(done1), .table_out(tab1),
        .err_count(err1), .err_idx(eidx1), .match(match1));

    truth_table_sequencer #(.N_IN(2), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .f_in(f3),
        .x_out(x3), .busy(busy3), .done(done3), .table_out(tab3),
        .err_count(err3), .err_idx(eidx3), .match(match3));

    // Pulse start on dut1, then count edges until done (bounded); n = latency from E0.
    task automatic run1(input int lat, input string name);
        int n;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n !== lat) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", name, n, lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({x1, busy1, done1, tab1, err1, eidx1, match1} !== '0) begin
            fails++;
            $display("FAIL reset dut1: got %b want 0", {x1, busy1, done1, tab1, err1, eidx1, match1});
        end
        tests++;
        if ({x3, busy3, done3, tab3, err3, eidx3, match3} !== '0) begin
            fails++;
            $display("FAIL reset dut3: got %b want 0", {x3, busy3, done3, tab3, err3, eidx3, match3});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_const();
        sel = 2'd0; exp1 = 4'b1111;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            if (j > 0) begin @(posedge clk); #1; end
            tests++;
            if (x1 !== 2'((j < 8) ? j / 2 : 3)) begin
                fails++;
                $display("FAIL const x_out@E0+%0d: got %0d want %0d", j, x1, (j < 8) ? j / 2 : 3);
            end
            tests++;
            if ({busy1, done1} !== ((j < 8) ? 2'b10 : 2'b01)) begin
                fails++;
                $display("FAIL const busy/done@E0+%0d: got %b", j, {busy1, done1});
            end
        end
        tests++;
        if ({tab1, err1, eidx1, match1} !== {4'b1111, 3'd0, 2'd0, 1'b1}) begin
            fails++;
            $display("FAIL const results: got tab=%b err=%0d idx=%0d match=%b", tab1, err1, eidx1, match1);
        end
    endtask

    task automatic test_and();
        sel = 2'd1; exp1 = 4'b1111;
`ifdef TT_HALT_ON_ERR_EN
        run1(2, "and");
        tests++;
        if ({tab1, err1, eidx1, match1, x1} !== {4'b0000, 3'd1, 2'd0, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL and results: got tab=%b err=%0d idx=%0d match=%b x=%0d", tab1, err1, eidx1, match1, x1);
        end
`else
        run1(8, "and");
        tests++;
        if ({tab1, err1, eidx1, match1} !== {4'b1000, 3'd3, 2'd0, 1'b0}) begin
            fails++;
            $display("FAIL and results: got tab=%b err=%0d idx=%0d match=%b", tab1, err1, eidx1, match1);
        end
`endif
    endtask

    // Single mismatch at vector 2 exercises a non-zero err_idx.
    task automatic test_err_idx();
        sel = 2'd0; exp1 = 4'b1011;
`ifdef TT_HALT_ON_ERR_EN
        run1(6, "erridx");
        tests++;
        if ({tab1, err1, eidx1, match1, x1} !== {4'b0111, 3'd1, 2'd2, 1'b0, 2'd2}) begin
            fails++;
            $display("FAIL erridx results: got tab=%b err=%0d idx=%0d match=%b x=%0d", tab1, err1, eidx1, match1, x1);
        end
`else
        run1(8, "erridx");
        tests++;
        if ({tab1, err1, eidx1, match1} !== {4'b1111, 3'd1, 2'd2, 1'b0}) begin
            fails++;
            $display("FAIL erridx results: got tab=%b err=%0d idx=%0d match=%b", tab1, err1, eidx1, match1);
        end
`endif
    endtask

    task automatic test_settle3();
        int n;
        exp3 = 4'b0110;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 200) begin
            tests++;
            if (x3 !== 2'(n / 4)) begin
                fails++;
                $display("FAIL settle3 x_out@E0+%0d: got %0d want %0d", n, x3, n / 4);
            end
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n !== 16) begin
            fails++;
            $display("FAIL settle3 latency: got %0d want 16", n);
        end
        tests++;
        if ({tab3, err3, eidx3, match3} !== {4'b0110, 3'd0, 2'd0, 1'b1}) begin
            fails++;
            $display("FAIL settle3 results: got tab=%b err=%0d idx=%0d match=%b", tab3, err3, eidx3, match3);
        end
    endtask

    task automatic test_reset_mid();
        sel = 2'd0; exp1 = 4'b1111;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests++;
        if ({x1, busy1, done1, tab1, err1, eidx1, match1} !== '0) begin
            fails++;
            $display("FAIL reset_mid outputs: got %b want 0", {x1, busy1, done1, tab1, err1, eidx1, match1});
        end
        run1(8, "reset_mid rescan");
        tests++;
        if ({tab1, match1} !== {4'b1111, 1'b1}) begin
            fails++;
            $display("FAIL reset_mid results: got tab=%b match=%b", tab1, match1);
        end
    endtask

    task automatic test_restart_busy();
        int n;
        sel = 2'd0; exp1 = 4'b1111;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = 0;
        while (!done1 && n < 200) begin
            start1 = (n == 2);
            @(posedge clk); #1;
            n++;
        end
        start1 = 1'b0;
        tests++;
        if (n !== 8) begin
            fails++;
            $display("FAIL restart_busy latency: got %0d want 8", n);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        sel = 2'd1; exp1 = 4'b1000;
        run1(8, "b2b first");
        start1 = 1'b1;
        @(posedge clk); #1;
        tests++;
        if ({busy1, done1, tab1, err1} !== {1'b1, 1'b0, 4'b0000, 3'd0}) begin
            fails++;
            $display("FAIL b2b restart: got busy=%b done=%b tab=%b err=%0d", busy1, done1, tab1, err1);
        end
        // start stays high: the scan restarts on the first DONE edge
        n = 0;
        while (!done1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if ({n[3:0], tab1, err1, match1} !== {4'd8, 4'b1000, 3'd0, 1'b1}) begin
            fails++;
            $display("FAIL b2b second: got lat=%0d tab=%b err=%0d match=%b", n, tab1, err1, match1);
        end
        @(posedge clk); #1;
        start1 = 1'b0;
        tests++;
        if ({busy1, done1} !== 2'b10) begin
            fails++;
            $display("FAIL b2b held start: got busy=%b done=%b want 1 0", busy1, done1);
        end
        while (!done1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_const();
        test_and();
        test_err_idx();
        test_settle3();
        test_reset_mid();
        test_restart_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
